// File: rtl/led_pkg.sv
// Shared LED constants and the breathing-FSM state type.
package led_pkg;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } breath_state_t;

    // Board clock shared with the blinker; 1953 cycles per step gives ~10 ms for a full fade.
    localparam int unsigned LED_CLK_HZ       = 32'd50_000_000;
    localparam int unsigned DEF_PWM_BITS     = 32'd8;
    localparam int unsigned DEF_STEP_DIV     = 32'd1953;

endpackage

// File: rtl/led_pwm_core.sv
// Free-running PWM counter with compare and true-100% override, registered output.
module led_pwm_core #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_out
);

    localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};

    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic                pwm_out_r;
    logic                pwm_nxt_s;

    // Compare against the free-running counter; full scale holds the pin high.
    always_comb begin
        pwm_nxt_s = 1'b0;
        if (duty == MAX) begin
            pwm_nxt_s = 1'b1;
        end else begin
            pwm_nxt_s = (pwm_cnt_r < duty);
        end
    end

    // Counter and registered pin drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_r <= {PWM_BITS{1'b0}};
            pwm_out_r <= 1'b0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
            pwm_out_r <= pwm_nxt_s;
        end
    end

    assign pwm_out = pwm_out_r;

endmodule

// File: rtl/led_breath_pwm.sv
// LED breathing driver: ramps brightness toward led_req and drives a PWM pin.
// Optional build macro LED_BREATH_GAMMA_EN adds a squared-brightness stage.
module led_breath_pwm
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS = DEF_PWM_BITS,
    parameter int unsigned STEP_DIV = DEF_STEP_DIV
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                led_req,
    output logic                led_pwm,
    output logic [PWM_BITS-1:0] level,
    output logic                busy
);

    localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
    localparam int unsigned         CNT_W     = (STEP_DIV > 32'd1) ? $clog2(STEP_DIV) : 32'd1;
    localparam logic [CNT_W-1:0]    STEP_LAST = CNT_W'(STEP_DIV - 32'd1);

    breath_state_t       state_r, state_nxt_s;
    logic [PWM_BITS-1:0] level_r, level_nxt_s;
    logic [CNT_W-1:0]    step_cnt_r, step_nxt_s;
    logic                busy_r;
    logic                tick_s;
    logic [PWM_BITS-1:0] duty_s;

    assign tick_s = (step_cnt_r == STEP_LAST);

    // Next state, level and step counter; a direction change beats a same-cycle tick.
    always_comb begin
        state_nxt_s = state_r;
        level_nxt_s = level_r;
        step_nxt_s  = step_cnt_r;
        if (!en) begin
            state_nxt_s = OFF;
            level_nxt_s = {PWM_BITS{1'b0}};
            step_nxt_s  = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                OFF: begin
                    if (led_req) begin
                        state_nxt_s = RAMP_UP;
                        step_nxt_s  = {CNT_W{1'b0}};
                    end else begin
                        step_nxt_s  = {CNT_W{1'b0}};
                    end
                end
                RAMP_UP: begin
                    if (!led_req) begin
                        state_nxt_s = RAMP_DOWN;
                        step_nxt_s  = {CNT_W{1'b0}};
                    end else if (tick_s) begin
                        step_nxt_s = {CNT_W{1'b0}};
                        if (level_r >= (MAX - PWM_BITS'(1))) begin
                            level_nxt_s = MAX;
                            state_nxt_s = ON;
                        end else begin
                            level_nxt_s = level_r + PWM_BITS'(1);
                        end
                    end else begin
                        step_nxt_s = step_cnt_r + CNT_W'(1);
                    end
                end
                ON: begin
                    if (!led_req) begin
                        state_nxt_s = RAMP_DOWN;
                        step_nxt_s  = {CNT_W{1'b0}};
                    end else begin
                        step_nxt_s  = {CNT_W{1'b0}};
                    end
                end
                RAMP_DOWN: begin
                    if (led_req) begin
                        state_nxt_s = RAMP_UP;
                        step_nxt_s  = {CNT_W{1'b0}};
                    end else if (tick_s) begin
                        step_nxt_s = {CNT_W{1'b0}};
                        if (level_r <= PWM_BITS'(1)) begin
                            level_nxt_s = {PWM_BITS{1'b0}};
                            state_nxt_s = OFF;
                        end else begin
                            level_nxt_s = level_r - PWM_BITS'(1);
                        end
                    end else begin
                        step_nxt_s = step_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt_s = OFF;
                    level_nxt_s = {PWM_BITS{1'b0}};
                    step_nxt_s  = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, level, divider and busy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= OFF;
            level_r    <= {PWM_BITS{1'b0}};
            step_cnt_r <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            level_r    <= level_nxt_s;
            step_cnt_r <= step_nxt_s;
            busy_r     <= (state_nxt_s == RAMP_UP) || (state_nxt_s == RAMP_DOWN);
        end
    end

`ifdef LED_BREATH_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq_s;
    logic [PWM_BITS-1:0]   gduty_s;
    logic [PWM_BITS-1:0]   gduty_r;

    // Squared brightness; full scale is pinned so ON stays a true 100%.
    always_comb begin
        sq_s = (2*PWM_BITS)'(level_r) * (2*PWM_BITS)'(level_r);
        if (level_r == MAX) begin
            gduty_s = MAX;
        end else begin
            gduty_s = sq_s[2*PWM_BITS-1:PWM_BITS];
        end
    end

    // Gamma pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gduty_r <= {PWM_BITS{1'b0}};
        end else begin
            gduty_r <= en ? gduty_s : {PWM_BITS{1'b0}};
        end
    end

    // en gates duty directly so the pin goes dark one cycle after en drops.
    assign duty_s = en ? gduty_r : {PWM_BITS{1'b0}};
`else
    assign duty_s = en ? level_r : {PWM_BITS{1'b0}};
`endif

    led_pwm_core #(
        .PWM_BITS (PWM_BITS)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .duty    (duty_s),
        .pwm_out (led_pwm)
    );

    assign level = level_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_led_breath_pwm.sv
// Self-checking bench for led_breath_pwm (PWM_BITS=4, STEP_DIV=4) with a behavioural model.
module tb_led_breath_pwm;

    localparam int PB   = 4;
    localparam int SDIV = 4;
    localparam int MAX  = 15;
    localparam int M_OFF = 0, M_UP = 1, M_ON = 2, M_DOWN = 3;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          led_req;
    logic          led_pwm;
    logic [PB-1:0] level;
    logic          busy;

    int vec_cnt = 0;
    int mis_cnt = 0;

    // model state: brightness, mode, cycles since mode entry/last step, outputs
    int m_lvl, m_mode, m_age, m_busy, m_pwm, m_cnt, m_gduty;

    led_breath_pwm #(.PWM_BITS(PB), .STEP_DIV(SDIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .led_req (led_req),
        .led_pwm (led_pwm),
        .level   (level),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            mis_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int gam(input int l);
        if (l == MAX) return MAX;
        return (l * l) / (1 << PB);
    endfunction

    task automatic model_reset();
        m_lvl = 0; m_mode = M_OFF; m_age = 0; m_busy = 0;
        m_pwm = 0; m_cnt = 0; m_gduty = 0;
    endtask

    // One clock of behaviour, computed from the previous model values.
    task automatic model_clock();
        int duty, nl, nm, na;
        bit up;
        if (!rst_n) begin
            model_reset();
            return;
        end
`ifdef LED_BREATH_GAMMA_EN
        duty = en ? m_gduty : 0;
`else
        duty = en ? m_lvl : 0;
`endif
        m_pwm   = (duty == MAX) ? 1 : ((m_cnt < duty) ? 1 : 0);
        m_cnt   = (m_cnt + 1) % (MAX + 1);
        m_gduty = en ? gam(m_lvl) : 0;
        nl = m_lvl; nm = m_mode; na = m_age;
        if (!en) begin
            nm = M_OFF; nl = 0; na = 0;
        end else if (m_mode == M_OFF) begin
            if (led_req) begin nm = M_UP; na = 0; end
        end else if (m_mode == M_ON) begin
            if (!led_req) begin nm = M_DOWN; na = 0; end
        end else begin
            up = (m_mode == M_UP);
            if (led_req != up) begin
                nm = led_req ? M_UP : M_DOWN; na = 0;
            end else if (m_age == SDIV - 1) begin
                na = 0;
                nl = up ? ((m_lvl + 1 > MAX) ? MAX : m_lvl + 1)
                        : ((m_lvl - 1 < 0) ? 0 : m_lvl - 1);
                if (up && nl == MAX) nm = M_ON;
                if (!up && nl == 0) nm = M_OFF;
            end else begin
                na = m_age + 1;
            end
        end
        m_lvl = nl; m_mode = nm; m_age = na;
        m_busy = (nm == M_UP || nm == M_DOWN) ? 1 : 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_clock();
        #1;
        check("level", level, m_lvl);
        check("busy", busy, m_busy);
        check("led_pwm", led_pwm, m_pwm);
    endtask

    initial begin
        int highs;
        rst_n = 1'b0; en = 1'b1; led_req = 1'b1;
        model_reset();

        // 1. reset held with led_req high, then release
        cyc(); cyc();
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_pwm", led_pwm, 0);
        rst_n = 1'b1;
        cyc();
        check("busy_after_release", busy, 1);
        repeat (4) cyc();
        check("level_first_step", level, 1);

        // 2. climb to full scale, then constant-high pin while ON
        for (int i = 0; i < 100 && m_mode != M_ON; i++) cyc();
        check("reach_max", level, MAX);
        repeat (2) cyc();
        for (int i = 0; i < 32; i++) begin
            cyc();
            check("on_pwm_high", led_pwm, 1);
            check("on_not_busy", busy, 0);
        end

        // 3. fade to dark, then constant-low pin while OFF
        led_req = 1'b0;
        for (int i = 0; i < 100 && m_mode != M_OFF; i++) cyc();
        check("reach_zero", level, 0);
        repeat (2) cyc();
        for (int i = 0; i < 32; i++) begin
            cyc();
            check("off_pwm_low", led_pwm, 0);
        end

        // 4. reversal mid-ramp, no jump
        led_req = 1'b1;
        for (int i = 0; i < 100 && m_lvl != 7; i++) cyc();
        check("mid_level7", level, 7);
        led_req = 1'b0;
        cyc();
        check("hold_on_reverse", level, 7);
        for (int i = 0; i < 100 && m_lvl != 3; i++) cyc();
        check("down_to3", level, 3);
        led_req = 1'b1;
        for (int i = 0; i < 100 && m_lvl != 4; i++) cyc();
        check("up_from3", level, 4);

        // 5. hold level 8 by toggling led_req each cycle, count duty
        for (int i = 0; i < 100 && m_lvl != 8; i++) cyc();
        check("level8", level, 8);
        for (int i = 0; i < 4; i++) begin led_req = ~led_req; cyc(); end
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            led_req = ~led_req;
            cyc();
            highs += int'(led_pwm);
        end
        check("level8_steady", level, 8);
`ifdef LED_BREATH_GAMMA_EN
        check("duty_highs", highs, 4);
`else
        check("duty_highs", highs, 8);
`endif

        // 6. async reset between edges, then en drop mid-ramp
        led_req = 1'b1;
        repeat (10) cyc();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_level", level, 0);
        check("async_busy", busy, 0);
        check("async_pwm", led_pwm, 0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 100 && m_lvl != 6; i++) cyc();
        en = 1'b0;
        cyc();
        check("en_off_level", level, 0);
        check("en_off_busy", busy, 0);
        check("en_off_pwm", led_pwm, 0);
        for (int i = 0; i < 8; i++) begin
            led_req = 1'($urandom_range(0, 1));
            cyc();
            check("en_off_ignore", level, 0);
        end
        en = 1'b1;

        // 7. randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) led_req = ~led_req;
            en = ($urandom_range(0, 149) != 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
